// File: rtl/otter_pkg.sv
// otter_pkg: shared OTTER constants, PC source codes and PC-unit state type
package otter_pkg;
  localparam int XLEN = 32;
  localparam int PC_NSRC = 6;
  localparam logic [2:0] PC_SRC_PLUS4 = 3'd0;
  localparam logic [2:0] PC_SRC_JALR = 3'd1;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
  localparam logic [2:0] PC_SRC_JAL = 3'd3;
  localparam logic [2:0] PC_SRC_MTVEC = 3'd4;
  localparam logic [2:0] PC_SRC_MEPC = 3'd5;
  typedef enum logic {IDLE, PEND_S} pc_state_t;
endpackage

// File: rtl/pc_next_reg_mux.sv
// mux_nt1_nb: combinational NSRC:1 mux of n-bit words with an in-range flag
module mux_nt1_nb #(
  parameter int n = 32,
  parameter int NSRC = 6
) (
  input  logic [$clog2(NSRC)-1:0] sel,
  input  logic [NSRC*n-1:0]       d,
  output logic [n-1:0]            y,
  output logic                    valid
);
  assign valid = int'(sel) < NSRC;
  assign y = valid ? d[int'(sel)*n +: n] : '0;
endmodule

// File: rtl/pc_next_reg.sv
// pc_next_reg: PC register with source mux and stall-tolerant redirect capture
module pc_next_reg
  import otter_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int NSRC = PC_NSRC,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter bit ALIGN_CHECK = 1'b1,
  localparam int SW = $clog2(NSRC)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PC_WE,
  input  logic [SW-1:0]         SEL,
  input  logic [NSRC*WIDTH-1:0] D,
  input  logic                  REDIR,
  input  logic [WIDTH-1:0]      REDIR_ADDR,
  output logic [WIDTH-1:0]      PC,
  output logic                  PEND,
  output logic                  SEL_ERR,
  output logic                  MISALIGN
);
  pc_state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pend_addr_q, pend_addr_d, mux_y;
  logic sel_err_q, sel_err_d, misalign_q, misalign_d, mux_valid, pc_wr;
  mux_nt1_nb #(.n(WIDTH), .NSRC(NSRC)) u_mux (
    .sel(SEL), .d(D), .y(mux_y), .valid(mux_valid)
  );
  // a live redirect beats a pending one, which beats the selected source
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_addr_d = pend_addr_q;
    sel_err_d = 1'b0;
    pc_wr = 1'b0;
    if (PC_WE) begin
      state_d = IDLE;
      pc_wr = REDIR || state_q == PEND_S || mux_valid;
      sel_err_d = !pc_wr;
      pc_d = REDIR ? REDIR_ADDR : state_q == PEND_S ? pend_addr_q : mux_valid ? mux_y : pc_q;
    end else if (REDIR) begin
      state_d = PEND_S;
      pend_addr_d = REDIR_ADDR;
    end
    misalign_d = pc_wr ? ALIGN_CHECK && pc_d[1:0] != 2'b00 : misalign_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q <= RESET_VEC;
      pend_addr_q <= '0;
      sel_err_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_addr_q <= pend_addr_d;
      sel_err_q <= sel_err_d;
      misalign_q <= misalign_d;
    end
  end
  assign PC = pc_q;
  assign PEND = state_q == PEND_S;
  assign SEL_ERR = sel_err_q;
  assign MISALIGN = misalign_q;
endmodule
